// File: rtl/mem_lower_pkg.sv
// Shared definitions for the lowered 1R1W masked memory.
//   - state_e      : controller states (INIT = zero-fill running, READY = serving requests)
//   - rf2 tie-offs : constant levels for the macro's margin, retention, test and scan pins
//   - clog2 / ceil_div : constant functions used to size addresses and the bank array
//   - cfg_ok       : geometry check the top evaluates at elaboration
package mem_lower_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // rf2 macro static pins. Functional mode: retention off, RAM bypass off,
  // test muxes selecting the functional ports, scan idle, default margins.
  localparam logic       COLLDISN  = 1'b1;
  localparam logic       DFTRAMBYP = 1'b0;
  localparam logic [2:0] EMAA      = 3'd3;
  localparam logic [2:0] EMAB      = 3'd3;
  localparam logic       EMASA     = 1'b0;
  localparam logic       RET1N     = 1'b1;
  localparam logic       TENA      = 1'b1;
  localparam logic       TENB      = 1'b1;
  localparam logic       TCENA     = 1'b1;
  localparam logic       TCENB     = 1'b1;
  localparam logic       SE        = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Lanes must tile the word exactly and fit inside one macro; macro depth
  // must be a power of two so the bank/offset split is a plain bit split.
  function automatic bit cfg_ok(input int depth, input int width, input int mask_gran,
                                input int macro_depth, input int macro_width);
    return (depth >= 2) && (mask_gran >= 1) && (width % mask_gran == 0) &&
           (mask_gran <= macro_width) && (macro_depth >= 2) &&
           ((macro_depth & (macro_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_1r1w_lane_macro.sv
// One rf2 dual-port macro covering one mask lane of one depth bank.
// The array below is the behavioural stand-in for the hard macro: port A is
// the synchronous read port, port B the write port, both with active-low
// chip enables. Lane data sits in the DB LSBs with the MSBs padded with 0;
// QA is truncated back to the lane width.
//   clock   : macro clock
//   rd_en   : read request (drives CENA low)
//   rd_addr : word within the macro
//   rd_data : QA LSBs, valid the cycle after rd_en, held otherwise
//   wr_en   : write request (drives CENB low)
//   wr_addr : word within the macro
//   wr_data : lane data to store
module mem_1r1w_lane_macro
  import mem_lower_pkg::*;
#(
  parameter int  MACRO_DEPTH = 32,
  parameter int  MACRO_WIDTH = 19,
  parameter int  MASK_GRAN   = 16,
  localparam int MAW         = clog2(MACRO_DEPTH)
) (
  input  logic                 clock,
  input  logic                 rd_en,
  input  logic [MAW-1:0]       rd_addr,
  output logic [MASK_GRAN-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [MAW-1:0]       wr_addr,
  input  logic [MASK_GRAN-1:0] wr_data
);

  logic                   cena, cenb;
  logic [MAW-1:0]         aa, ab;
  logic [MACRO_WIDTH-1:0] db, qa;
  logic                   ret1n, dftrambyp, tena, tenb, tcena, tcenb, colldisn, se, emasa;
  logic [2:0]             emaa, emab;

  assign cena      = ~rd_en;
  assign cenb      = ~wr_en;
  assign aa        = rd_addr;
  assign ab        = wr_addr;
  assign db        = MACRO_WIDTH'(wr_data);
  assign ret1n     = RET1N;
  assign dftrambyp = DFTRAMBYP;
  assign tena      = TENA;
  assign tenb      = TENB;
  assign tcena     = TCENA;
  assign tcenb     = TCENB;
  assign colldisn  = COLLDISN;
  assign se        = SE;
  assign emaa      = EMAA;
  assign emab      = EMAB;
  assign emasa     = EMASA;

  // Margin, collision-detect and scan pins only tune the silicon.
  logic margin_pins_unused;
  assign margin_pins_unused = ^{emaa, emab, emasa, colldisn, se};

  logic macro_on, cena_eff, cenb_eff;
  assign macro_on = ret1n & ~dftrambyp;
  assign cena_eff = tena ? cena : tcena;
  assign cenb_eff = tenb ? cenb : tcenb;

  logic [MACRO_WIDTH-1:0] array_q [MACRO_DEPTH];

  // NOTE: storage arrays get no reset branch -- a reset would turn the array
  // into flops; clearing contents is the job of the zero-fill engine.
  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (macro_on && !cenb_eff) array_q[ab] <= db;
    if (macro_on && !cena_eff) qa <= array_q[aa];
  end

  logic qa_msb_unused;
  assign qa_msb_unused = ^(qa >> MASK_GRAN);
  assign rd_data       = qa[MASK_GRAN-1:0];

endmodule

// File: rtl/mem_1r1w_wmask_lowered.sv
// 1R1W masked memory lowered onto rf2 macros: NB depth banks x NL lanes.
// Adds same-address read-during-write forwarding, optional output register
// and a zero-fill engine that clears every word after reset or init_start.
//   clock, reset : single clock, asynchronous active-high reset
//   R0_addr/R0_en : read request; result on R0_data/R0_valid 1+OUT_REG cycles later
//   W0_addr/W0_en/W0_data/W0_mask : write request with per-lane enables
//   init_start : in READY, restart the zero-fill
//   ready : high when requests are accepted
module mem_1r1w_wmask_lowered
  import mem_lower_pkg::*;
#(
  parameter int  DEPTH         = 48,
  parameter int  WIDTH         = 64,
  parameter int  MASK_GRAN     = 16,
  parameter int  MACRO_DEPTH   = 32,
  parameter int  MACRO_WIDTH   = 19,
  parameter bit  OUT_REG       = 1'b0,
  parameter bit  INIT_ON_RESET = 1'b1,
  localparam int AW            = clog2(DEPTH),
  localparam int NL            = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [NL-1:0]    W0_mask,
  input  logic             init_start,
  output logic             ready
);

  localparam int            MAW       = clog2(MACRO_DEPTH);
  localparam int            NB        = ceil_div(DEPTH, MACRO_DEPTH);
  localparam int            BW        = (NB > 1) ? clog2(NB) : 1;
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if (!cfg_ok(DEPTH, WIDTH, MASK_GRAN, MACRO_DEPTH, MACRO_WIDTH)) begin : g_bad_cfg
    $error("mem_1r1w_wmask_lowered: unsupported DEPTH/WIDTH/MASK_GRAN/MACRO geometry");
  end

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
    return BW'(a >> MAW);
  endfunction

  // ---------------- controller: zero-fill FSM ----------------
  state_e        state_q;
  logic [AW-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT_ON_RESET ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (init_start) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign ready = (state_q == READY);

  // ---------------- request qualification ----------------
  logic rd_in_range, wr_in_range, rd_go, wr_user, collide;

  assign rd_in_range = {1'b0, R0_addr} < DEPTH_W;
  assign wr_in_range = {1'b0, W0_addr} < DEPTH_W;
  assign rd_go       = ready & R0_en;
  assign wr_user     = ready & W0_en & wr_in_range;
  // Same-word read and write: the written lanes are served from the bypass
  // registers, so those macros never see a simultaneous read of that word.
  assign collide     = rd_go & rd_in_range & wr_user & (R0_addr == W0_addr);

  // Write port: zero-fill owns it during INIT, otherwise the user request.
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NL-1:0]    wr_lanes;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held (no latch).
  always_comb begin
    wr_addr  = W0_addr;
    wr_data  = W0_data;
    wr_lanes = wr_user ? W0_mask : '0;
    if (state_q == INIT) begin
      wr_addr  = cnt_q;
      wr_data  = '0;
      wr_lanes = '1;
    end
  end

  // ---------------- macro array ----------------
  logic [MASK_GRAN-1:0] lane_q [NB][NL];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic rd_hit, wr_hit;
    assign rd_hit = rd_go & rd_in_range & (bank_of(R0_addr) == BW'(b));
    assign wr_hit = (bank_of(wr_addr) == BW'(b));

    for (genvar l = 0; l < NL; l++) begin : g_lane
      mem_1r1w_lane_macro #(
        .MACRO_DEPTH(MACRO_DEPTH),
        .MACRO_WIDTH(MACRO_WIDTH),
        .MASK_GRAN  (MASK_GRAN)
      ) u_macro (
        .clock  (clock),
        .rd_en  (rd_hit & ~(collide & W0_mask[l])),
        .rd_addr(MAW'(R0_addr)),
        .rd_data(lane_q[b][l]),
        .wr_en  (wr_hit & wr_lanes[l]),
        .wr_addr(MAW'(wr_addr)),
        .wr_data(wr_data[l*MASK_GRAN +: MASK_GRAN])
      );
    end
  end

  // ---------------- read-side bookkeeping and bypass ----------------
  logic             rd_valid_q, rd_oor_q;
  logic [BW-1:0]    rd_bank_q;
  logic [NL-1:0]    byp_lanes_q;
  logic [WIDTH-1:0] byp_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
      rd_bank_q   <= '0;
      byp_lanes_q <= '0;
      byp_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        rd_oor_q    <= ~rd_in_range;
        rd_bank_q   <= bank_of(R0_addr);
        byp_lanes_q <= collide ? W0_mask : '0;
        byp_data_q  <= W0_data;
      end
    end
  end

  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (!rd_oor_q) begin
      for (int l = 0; l < NL; l++) begin
        rd_mux[l*MASK_GRAN +: MASK_GRAN] = byp_lanes_q[l] ? byp_data_q[l*MASK_GRAN +: MASK_GRAN]
                                                          : lane_q[rd_bank_q][l];
      end
    end
  end

  // Last delivered word: holds R0_data between reads and, with OUT_REG,
  // doubles as the output pipeline register.
  logic [WIDTH-1:0] data_last_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) data_last_q <= '0;
    else if (rd_valid_q) data_last_q <= rd_mux;
  end

  if (OUT_REG) begin : g_out_reg
    logic valid_pipe_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) valid_pipe_q <= 1'b0;
      else valid_pipe_q <= rd_valid_q;
    end
    assign R0_data  = data_last_q;
    assign R0_valid = valid_pipe_q;
  end else begin : g_out_comb
    assign R0_data  = rd_valid_q ? rd_mux : data_last_q;
    assign R0_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_mem_1r1w_wmask_lowered.sv
// Self-checking bench for mem_1r1w_wmask_lowered (default geometry).
// A word-level reference model (array of words, pending-read queue, count of
// remaining zero-fill cycles) predicts ready, R0_valid and R0_data every cycle;
// a table of directed vectors and a few hand-written sequences add fixed
// expected values for the documented corner cases.
module tb_mem_1r1w_wmask_lowered;

  localparam int DEPTH   = 48;
  localparam int WIDTH   = 64;
  localparam int GRAN    = 16;
  localparam int NL      = WIDTH / GRAN;
  localparam int AW      = 6;
  localparam bit OUT_REG = 1'b0;
  localparam int LAT     = OUT_REG ? 2 : 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [AW-1:0]    R0_addr = '0;
  logic             R0_en = 1'b0;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic [AW-1:0]    W0_addr = '0;
  logic             W0_en = 1'b0;
  logic [WIDTH-1:0] W0_data = '0;
  logic [NL-1:0]    W0_mask = '0;
  logic             init_start = 1'b0;
  logic             ready;

  always #5 clock = ~clock;

  mem_1r1w_wmask_lowered #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .MACRO_DEPTH(32), .MACRO_WIDTH(19),
    .OUT_REG(OUT_REG), .INIT_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data), .R0_valid(R0_valid),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .init_start(init_start), .ready(ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
  } pend_t;

  logic [63:0] m_mem [DEPTH];
  int          m_init_left = 0;
  logic [63:0] m_last = '0;
  pend_t       exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_start_init();
    m_init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Effect of one cycle's inputs. A read sees the word as it stands after
  // this cycle's write, which gives new data on written lanes and old data
  // on the rest for a same-address collision.
  task automatic model_step(input logic r_en, input logic [AW-1:0] r_addr, input logic w_en,
                            input logic [AW-1:0] w_addr, input logic [63:0] w_data,
                            input logic [NL-1:0] w_mask, input logic istart);
    logic [63:0] rv;
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (w_en && int'(w_addr) < DEPTH) begin
        for (int l = 0; l < NL; l++)
          if (w_mask[l]) m_mem[w_addr][l*GRAN +: GRAN] = w_data[l*GRAN +: GRAN];
      end
      if (r_en) begin
        rv = (int'(r_addr) < DEPTH) ? m_mem[r_addr] : 64'h0;
        exp_q.push_back('{cyc + LAT, rv});
      end
      if (istart) model_start_init();
    end
  endtask

  // One clock cycle: check ready, drive, advance, check the read outputs.
  task automatic drive_cycle(input logic r_en, input logic [AW-1:0] r_addr, input logic w_en,
                             input logic [AW-1:0] w_addr, input logic [63:0] w_data,
                             input logic [NL-1:0] w_mask, input logic istart);
    logic        e_valid;
    logic [63:0] e_data;
    check("ready", 64'(ready), (m_init_left == 0) ? 64'd1 : 64'd0);
    R0_en = r_en; R0_addr = r_addr;
    W0_en = w_en; W0_addr = w_addr; W0_data = w_data; W0_mask = w_mask;
    init_start = istart;
    model_step(r_en, r_addr, w_en, w_addr, w_data, w_mask, istart);
    @(posedge clock); #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_valid = 1'b1;
      e_data  = exp_q[0].data;
      m_last  = e_data;
      void'(exp_q.pop_front());
    end else begin
      e_valid = 1'b0;
      e_data  = m_last;
    end
    check("r0_valid", 64'(R0_valid), 64'(e_valid));
    check("r0_data", R0_data, e_data);
  endtask

  task automatic idle();
    drive_cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic random_cycle(input bit allow_istart);
    logic [AW-1:0] ra, wa;
    ra = AW'($urandom_range(0, 55));
    wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 55));
    drive_cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                {$urandom, $urandom}, NL'($urandom_range(0, 15)),
                1'(allow_istart && ($urandom_range(0, 99) == 0)));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    R0_en = 1'b0; W0_en = 1'b0; init_start = 1'b0;
    #2;
    check("reset_r0_valid", 64'(R0_valid), 64'd0);
    check("reset_r0_data", R0_data, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    @(posedge clock); #1;
    cyc++;
    reset = 1'b0;
    model_start_init();
    exp_q.delete();
    m_last = '0;
  endtask

  // Counts INIT cycles (requests driven meanwhile must be ignored).
  task automatic wait_ready(input string name, input int exp_len);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      random_cycle(1'b1);
      n++;
    end
    check(name, 64'(n), 64'(exp_len));
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!ready && n < 200) begin
      idle();
      n++;
    end
    check("settle_ready", 64'(ready), 64'd1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++)
      drive_cycle(1'b0, '0, 1'b1, AW'(a), {$urandom, $urandom}, '1, 1'b0);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, AW'(a), 1'b0, '0, '0, '0, 1'b0);
      repeat (LAT - 1) idle();
      check(name, R0_data, 64'h0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [63:0]   w_data;
    logic [NL-1:0] w_mask;
    logic [AW-1:0] r_addr;
    logic          same;
    logic [63:0]   exp;
    string         name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd0,  1'b0, 64'h0, "init_addr0"};
    vecs[1]  = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd31, 1'b0, 64'h0, "init_addr31"};
    vecs[2]  = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd32, 1'b0, 64'h0, "init_addr32"};
    vecs[3]  = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd47, 1'b0, 64'h0, "init_addr47"};
    vecs[4]  = '{1'b1, 6'd40, 64'h0123_4567_89AB_CDEF, 4'hF, 6'd40, 1'b0,
                 64'h0123_4567_89AB_CDEF, "full_write_40"};
    vecs[5]  = '{1'b1, 6'd5,  64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 6'd5, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, "preload_5"};
    vecs[6]  = '{1'b1, 6'd5,  64'h0, 4'b0101, 6'd5, 1'b0,
                 64'hFFFF_0000_FFFF_0000, "partial_5"};
    vecs[7]  = '{1'b1, 6'd33, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF, 6'd33, 1'b0,
                 64'hAAAA_AAAA_AAAA_AAAA, "preload_33"};
    vecs[8]  = '{1'b1, 6'd33, 64'h5555_5555_5555_5555, 4'b0011, 6'd33, 1'b1,
                 64'hAAAA_AAAA_5555_5555, "collision_33"};
    vecs[9]  = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd33, 1'b0,
                 64'hAAAA_AAAA_5555_5555, "after_collision_33"};
    vecs[10] = '{1'b1, 6'd18, 64'h1818_1818_1818_1818, 4'hF, 6'd18, 1'b0,
                 64'h1818_1818_1818_1818, "preload_18"};
    vecs[11] = '{1'b1, 6'd50, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 6'd50, 1'b0,
                 64'h0, "oor_read_50"};
    vecs[12] = '{1'b0, 6'd0,  64'h0, 4'h0, 6'd18, 1'b0,
                 64'h1818_1818_1818_1818, "oor_no_alias_18"};
    vecs[13] = '{1'b1, 6'd47, 64'h7777_7777_7777_7777, 4'b1000, 6'd47, 1'b0,
                 64'h7777_0000_0000_0000, "top_lane_47"};
  end

  // ---------------- main sequence ----------------
  initial begin
    #0;
    do_reset();
    wait_ready("init_len_poweron", DEPTH);

    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].same && vecs[i].w_en)
        drive_cycle(1'b0, '0, 1'b1, vecs[i].w_addr, vecs[i].w_data, vecs[i].w_mask, 1'b0);
      drive_cycle(1'b1, vecs[i].r_addr, vecs[i].same & vecs[i].w_en, vecs[i].w_addr,
                  vecs[i].w_data, vecs[i].w_mask, 1'b0);
      repeat (LAT - 1) idle();
      check({vecs[i].name, "_valid"}, 64'(R0_valid), 64'd1);
      check(vecs[i].name, R0_data, vecs[i].exp);
    end

    for (int i = 0; i < 400; i++) random_cycle(1'b1);
    settle();

    // init_start in READY with a same-cycle read that must still be served.
    fill_random();
    drive_cycle(1'b1, 6'd40, 1'b0, '0, '0, '0, 1'b1);
    wait_ready("init_len_restart", DEPTH);
    read_all_zero("zero_after_restart");

    // Reset in the middle of a fill restarts it from address 0.
    fill_random();
    drive_cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++) random_cycle(1'b1);
    do_reset();
    wait_ready("init_len_after_mid_reset", DEPTH);
    read_all_zero("zero_after_mid_reset");

    for (int i = 0; i < 200; i++) random_cycle(1'b0);
    repeat (LAT + 1) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
